// File: rtl/req_arbiter.sv
// req_arbiter: 8-way request arbiter with fixed-priority or round-robin
// selection, a one-cycle release gap and an optional hold timeout.
module req_arbiter #(
    parameter int MODE    = 1,
    parameter int TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       none_req,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST =
        (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);
    localparam logic       TO_EN   = (TIMEOUT != 0);

    state_t     state_q;
    logic [7:0] gnt_q;
    logic [2:0] idx_q;
    logic       valid_q;
    logic       to_q;
    logic [7:0] hold_q;
    logic [2:0] last_q;

    logic [2:0] win_d;
    logic       expire_d;
    logic       own_req_d;
    logic       release_d;

    // Winner selection: highest index, or descending search after last_q.
    always_comb begin
        logic       found;
        logic [2:0] cand;
        win_d = 3'd0;
        found = 1'b0;
        cand  = 3'd0;
        if (MODE == 0) begin
            for (int i = 0; i < 8; i++) begin
                if (req[i]) win_d = 3'(i);
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                cand = last_q - 3'(k + 1);
                if (!found && req[cand]) begin
                    win_d = cand;
                    found = 1'b1;
                end
            end
        end
    end

    // Release conditions evaluated while a grant is held.
    always_comb begin
        own_req_d = req[idx_q];
        expire_d  = TO_EN && (hold_q == TO_LAST);
        release_d = done || !own_req_d || expire_d;
    end

    // Arbitration FSM with registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 8'h00;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
            to_q    <= 1'b0;
            hold_q  <= 8'd0;
            last_q  <= 3'd0;
        end else begin
            to_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q <= GRANT;
                        gnt_q   <= 8'd1 << win_d;
                        idx_q   <= win_d;
                        valid_q <= 1'b1;
                        last_q  <= win_d;
                        hold_q  <= 8'd0;
                    end
                end
                GRANT: begin
                    if (release_d) begin
                        state_q <= GAP;
                        gnt_q   <= 8'h00;
                        valid_q <= 1'b0;
                        to_q    <= expire_d && !done && own_req_d;
                    end else if (hold_q != 8'hFF) begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign timeout   = to_q;
    assign none_req  = (req == 8'h00);

endmodule

// File: tb/tb_req_arbiter.sv
// tb_req_arbiter: directed checks of fixed priority, round-robin,
// timeout, request withdrawal, async reset and idle behaviour.
module tb_req_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;

    logic [7:0] gnt0, gnt1, gnt2;
    logic [2:0] idx0, idx1, idx2;
    logic       val0, val1, val2;
    logic       nr0, nr1, nr2;
    logic       to0, to1, to2;

    int n_checks;
    int n_errors;

    req_arbiter #(.MODE(0), .TIMEOUT(8)) u_fp (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(val0),
        .none_req(nr0), .timeout(to0)
    );

    req_arbiter #(.MODE(1), .TIMEOUT(8)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt1), .gnt_idx(idx1), .gnt_valid(val1),
        .none_req(nr1), .timeout(to1)
    );

    req_arbiter #(.MODE(1), .TIMEOUT(4)) u_to (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt2), .gnt_idx(idx2), .gnt_valid(val2),
        .none_req(nr2), .timeout(to2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [2:0] e;
        n_checks = 0;
        n_errors = 0;
        req   = 8'h00;
        done  = 1'b0;
        rst_n = 1'b0;
        #3;
        chk("rst_gnt", 32'(gnt1), 32'h00);
        chk("rst_idx", 32'(idx1), 32'd0);
        chk("rst_val", 32'(val1), 32'd0);
        chk("rst_to",  32'(to2),  32'd0);
        step();
        rst_n = 1'b1;

        // Idle and none_req
        for (int c = 0; c < 10; c++) begin
            step();
            chk("idle_nr",  32'(nr1),  32'd1);
            chk("idle_gnt", 32'(gnt1), 32'h00);
            chk("idle_val", 32'(val1), 32'd0);
        end
        req = 8'h10;
        #1;
        chk("nr_fall",   32'(nr1),  32'd0);
        chk("nr_nognt",  32'(gnt1), 32'h00);
        step();
        chk("idle_gnt10", 32'(gnt1), 32'h10);
        chk("idle_fp10",  32'(gnt0), 32'h10);
        req = 8'h00;
        step();
        step();

        // Fixed priority
        do_reset();
        req = 8'b0010_0110;
        step();
        chk("fp_gnt",  32'(gnt0), 32'h20);
        chk("fp_idx",  32'(idx0), 32'd5);
        chk("fp_val",  32'(val0), 32'd1);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("fp_gap",    32'(gnt0), 32'h00);
        chk("fp_gapval", 32'(val0), 32'd0);
        chk("fp_gapidx", 32'(idx0), 32'd5);
        step();
        chk("fp_idle", 32'(gnt0), 32'h00);
        step();
        chk("fp_regnt", 32'(gnt0), 32'h20);

        // Round-robin
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            e = 3'(7 - k);
            step();
            chk("rr_idx", 32'(idx1), 32'(e));
            chk("rr_gnt", 32'(gnt1), 32'(8'd1 << e));
            done = 1'b1;
            step();
            done = 1'b0;
            chk("rr_gap", 32'(gnt1), 32'h00);
            step();
        end

        // Timeout
        do_reset();
        req = 8'h01;
        step();
        chk("to_gnt0", 32'(gnt2), 32'h01);
        chk("to_pls0", 32'(to2),  32'd0);
        for (int c = 1; c < 4; c++) begin
            step();
            chk("to_hold", 32'(gnt2), 32'h01);
            chk("to_nopl", 32'(to2),  32'd0);
        end
        step();
        chk("to_gap",   32'(gnt2), 32'h00);
        chk("to_pulse", 32'(to2),  32'd1);
        chk("to8_hold", 32'(gnt1), 32'h01);
        chk("to8_nopl", 32'(to1),  32'd0);
        step();
        chk("to_pend", 32'(to2),  32'd0);
        chk("to_idle", 32'(gnt2), 32'h00);
        step();
        chk("to_regnt", 32'(gnt2), 32'h01);
        chk("to_reidx", 32'(idx2), 32'd0);
        step();
        step();
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        chk("to_done_gap", 32'(gnt2), 32'h00);
        chk("to_done_pl",  32'(to2),  32'd0);
        req = 8'h00;

        // Request withdrawal
        do_reset();
        req = 8'h08;
        step();
        chk("wd_gnt3", 32'(gnt0), 32'h08);
        chk("wd_idx3", 32'(idx0), 32'd3);
        req = 8'h48;
        step();
        chk("wd_keep", 32'(gnt0), 32'h08);
        req = 8'h40;
        step();
        chk("wd_gap", 32'(gnt0), 32'h00);
        step();
        chk("wd_idle", 32'(gnt0), 32'h00);
        step();
        chk("wd_idx6", 32'(idx0), 32'd6);
        chk("wd_gnt6", 32'(gnt0), 32'h40);

        // Async reset mid-grant
        do_reset();
        req = 8'h81;
        step();
        chk("ar_g7a", 32'(idx1), 32'd7);
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        step();
        chk("ar_g0", 32'(idx1), 32'd0);
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        step();
        chk("ar_g7b", 32'(gnt1), 32'h80);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_gnt", 32'(gnt1), 32'h00);
        chk("ar_val", 32'(val1), 32'd0);
        chk("ar_idx", 32'(idx1), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("ar_first", 32'(idx1), 32'd7);
        chk("ar_fgnt",  32'(gnt1), 32'h80);
        req = 8'h00;
        step();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
